power_series_eval: RTL and testbench

- Sequential consumer of the float32 power table `x^0..x^30` that the power generator produces.
- Evaluates `sum_{k=0}^{N_TERMS-1} c_k * x^k` one term per cycle.
- Uses one `multiply` instance and one float32 adder instance: the codebase adder, ports `inputA`/`inputB`/`out`.
- Sits between the power generator and downstream activation/approximation logic. Coefficients come from an external same-cycle lookup.

---
 rtl/power_series_eval.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_power_series_eval.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_series_eval.sv
// power_series_eval: sequential float32 power-series evaluator.
// Captures a table of x^0..x^30 and accumulates c_k * x^k one term per cycle,
// strictly in ascending k, using a single multiplier and a single adder.
// Optional feature macro: SERIES_TERM_LIMIT_EN (adds the n_terms input that
// limits the number of evaluated terms per run).
// The shared float32 multiply and adder cores live in this file as well.

module multiply (
  input  logic [31:0] inputA,
  input  logic [31:0] inputB,
  output logic [31:0] out
);
  logic               sign;
  logic [7:0]         ea, eb;
  logic [22:0]        fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]        prod;
  logic [23:0]        mant;
  logic               guard, sticky, round_up;
  logic [24:0]        rounded;
  logic signed [10:0] expo;

  // Round-to-nearest-even product; subnormal inputs count as zero and
  // underflowing results flush to signed zero.
  always_comb begin
    ea       = inputA[30:23];
    eb       = inputB[30:23];
    fa       = inputA[22:0];
    fb       = inputB[22:0];
    sign     = inputA[31] ^ inputB[31];
    a_zero   = (ea == 8'h00);
    b_zero   = (eb == 8'h00);
    a_inf    = (ea == 8'hFF) && (fa == 23'h0);
    b_inf    = (eb == 8'hFF) && (fb == 23'h0);
    a_nan    = (ea == 8'hFF) && (fa != 23'h0);
    b_nan    = (eb == 8'hFF) && (fb != 23'h0);
    prod     = 48'({1'b1, fa}) * 48'({1'b1, fb});
    expo     = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;
    mant     = prod[46:23];
    guard    = prod[22];
    sticky   = |prod[21:0];
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      expo   = expo + 11'sd1;
    end
    round_up = guard & (sticky | mant[0]);
    rounded  = {1'b0, mant} + {24'h0, round_up};
    if (rounded[24]) begin
      rounded = rounded >> 1;
      expo    = expo + 11'sd1;
    end
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      out = 32'h7FC00000;
    end else if (a_inf || b_inf) begin
      out = {sign, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      out = {sign, 31'h0};
    end else if (expo >= 11'sd255) begin
      out = {sign, 8'hFF, 23'h0};
    end else if (expo <= 11'sd0) begin
      out = {sign, 31'h0};
    end else begin
      out = {sign, expo[7:0], rounded[22:0]};
    end
  end
endmodule

module adder (
  input  logic [31:0] inputA,
  input  logic [31:0] inputB,
  output logic [31:0] out
);
  logic               sa, sb, big_s, small_s;
  logic [7:0]         ea, eb, big_e, small_e, shamt;
  logic [22:0]        fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [26:0]        big_m, small_m, aligned, norm;
  logic [27:0]        sum;
  logic [4:0]         lz;
  logic               round_up;
  logic [24:0]        rounded;
  logic signed [10:0] expo;

  // Align the smaller operand with guard/round/sticky bits, add or subtract
  // magnitudes, renormalise and round to nearest even.
  always_comb begin
    sa      = inputA[31];
    sb      = inputB[31];
    ea      = inputA[30:23];
    eb      = inputB[30:23];
    fa      = inputA[22:0];
    fb      = inputB[22:0];
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
    a_inf   = (ea == 8'hFF) && (fa == 23'h0);
    b_inf   = (eb == 8'hFF) && (fb == 23'h0);
    a_nan   = (ea == 8'hFF) && (fa != 23'h0);
    b_nan   = (eb == 8'hFF) && (fb != 23'h0);
    big_s   = sa;
    big_e   = ea;
    big_m   = {1'b1, fa, 3'b000};
    small_s = sb;
    small_e = eb;
    small_m = {1'b1, fb, 3'b000};
    if ({ea, fa} < {eb, fb}) begin
      big_s   = sb;
      big_e   = eb;
      big_m   = {1'b1, fb, 3'b000};
      small_s = sa;
      small_e = ea;
      small_m = {1'b1, fa, 3'b000};
    end
    shamt = big_e - small_e;
    if (shamt > 8'd26) begin
      aligned = 27'd1;
    end else begin
      aligned    = small_m >> shamt;
      aligned[0] = aligned[0] | (|(small_m & ((27'd1 << shamt) - 27'd1)));
    end
    expo = $signed({3'b000, big_e});
    lz   = 5'd0;
    sum  = 28'h0;
    norm = 27'h0;
    if (big_s == small_s) begin
      sum  = {1'b0, big_m} + {1'b0, aligned};
      norm = sum[26:0];
      if (sum[27]) begin
        norm = {sum[27:2], sum[1] | sum[0]};
        expo = expo + 11'sd1;
      end
    end else begin
      sum = {1'b0, big_m} - {1'b0, aligned};
      for (int i = 0; i < 27; i++) begin
        if (sum[i]) lz = 5'(26 - i);
      end
      norm = sum[26:0] << lz;
      expo = expo - $signed({6'b000000, lz});
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[26:3]} + {24'h0, round_up};
    if (rounded[24]) begin
      rounded = rounded >> 1;
      expo    = expo + 11'sd1;
    end
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      out = 32'h7FC00000;
    end else if (a_inf) begin
      out = inputA;
    end else if (b_inf) begin
      out = inputB;
    end else if (a_zero && b_zero) begin
      out = {sa & sb, 31'h0};
    end else if (a_zero) begin
      out = inputB;
    end else if (b_zero) begin
      out = inputA;
    end else if (norm == 27'h0) begin
      out = 32'h0;
    end else if (expo >= 11'sd255) begin
      out = {big_s, 8'hFF, 23'h0};
    end else if (expo <= 11'sd0) begin
      out = {big_s, 31'h0};
    end else begin
      out = {big_s, expo[7:0], rounded[22:0]};
    end
  end
endmodule

module power_series_eval #(
  parameter int N_TERMS = 31,
  parameter int IDX_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [30:0][31:0] power_table,
`ifdef SERIES_TERM_LIMIT_EN
  input  logic [IDX_W-1:0]  n_terms,
`endif
  output logic [IDX_W-1:0]  coeff_addr,
  input  logic [31:0]       coeff_data,
  output logic [31:0]       result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state, state_next;
  logic [30:0][31:0] table_q;
  logic [31:0]       acc, term, sum;
  logic [CNT_W-1:0]  limit, last_idx;
  logic              accept, finish, handoff;

  multiply u_multiply (
    .inputA (coeff_data),
    .inputB (table_q[coeff_addr]),
    .out    (term)
  );

  adder u_adder (
    .inputA (acc),
    .inputB (term),
    .out    (sum)
  );

`ifdef SERIES_TERM_LIMIT_EN
  // Latch the effective term count on accept so n_terms may change mid-run.
  always_ff @(posedge clk) begin
    if (rst) begin
      limit <= '0;
    end else if (accept) begin
      limit <= ({1'b0, n_terms} < CNT_W'(N_TERMS)) ? {1'b0, n_terms} : CNT_W'(N_TERMS);
    end
  end
`else
  assign limit = CNT_W'(N_TERMS);
`endif

  assign last_idx = limit - CNT_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake decode; a zero-term run spends one idle ACCUM cycle.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    handoff    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        busy = 1'b1;
        if ((limit == '0) || ({1'b0, coeff_addr} == last_idx)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          handoff    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: table capture, in-order accumulation and result hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      table_q    <= '0;
      acc        <= '0;
      coeff_addr <= '0;
      result     <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (accept) begin
        table_q    <= power_table;
        acc        <= '0;
        coeff_addr <= '0;
      end
      if ((state == ACCUM) && (limit != '0)) begin
        acc <= sum;
      end
      if (finish) begin
        result     <= (limit == '0) ? acc : sum;
        out_valid  <= 1'b1;
        coeff_addr <= '0;
      end else if (state == ACCUM) begin
        coeff_addr <= coeff_addr + IDX_W'(1);
      end
      if (handoff) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_power_series_eval.sv
// tb_power_series_eval: scoreboard bench for power_series_eval.
// Two instances share clock and reset: a 4-term unit for most scenarios and
// a full 31-term unit for full-length and mid-run reset scenarios.
// Expected sums use exactly representable values (powers of two, small integers).

module tb_power_series_eval;
  localparam int          IDX_W = 5;
  localparam logic [31:0] ONE   = 32'h3F800000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic              in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [30:0][31:0] table4;
  logic [IDX_W-1:0]  coeff_addr4;
  logic [31:0]       coeff_data4, result4;
  logic [31:0]       coeff4 [0:31];
  logic [31:0]       exp_q4 [$];
  logic [IDX_W-1:0]  addr_log4 [$];

  logic              in_valid31, in_ready31, out_valid31, out_ready31, busy31;
  logic [30:0][31:0] table31;
  logic [IDX_W-1:0]  coeff_addr31;
  logic [31:0]       coeff_data31, result31;
  logic [31:0]       coeff31 [0:31];
  logic [31:0]       exp_q31 [$];
  logic [IDX_W-1:0]  addr_log31 [$];

`ifdef SERIES_TERM_LIMIT_EN
  logic [IDX_W-1:0]  n_terms4, n_terms31;
`endif

  always #5 clk = ~clk;

  // The coefficient lookup is combinational from coeff_addr, as a same-cycle ROM.
  assign coeff_data4  = coeff4[coeff_addr4];
  assign coeff_data31 = coeff31[coeff_addr31];

  power_series_eval #(.N_TERMS(4), .IDX_W(IDX_W)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid4),
    .in_ready    (in_ready4),
    .power_table (table4),
`ifdef SERIES_TERM_LIMIT_EN
    .n_terms     (n_terms4),
`endif
    .coeff_addr  (coeff_addr4),
    .coeff_data  (coeff_data4),
    .result      (result4),
    .out_valid   (out_valid4),
    .out_ready   (out_ready4),
    .busy        (busy4)
  );

  power_series_eval #(.N_TERMS(31), .IDX_W(IDX_W)) u_dut31 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid31),
    .in_ready    (in_ready31),
    .power_table (table31),
`ifdef SERIES_TERM_LIMIT_EN
    .n_terms     (n_terms31),
`endif
    .coeff_addr  (coeff_addr31),
    .coeff_data  (coeff_data31),
    .result      (result31),
    .out_valid   (out_valid31),
    .out_ready   (out_ready31),
    .busy        (busy31)
  );

  // Table of (2^e)^k for k = 0..30; exact because every entry is a power of two.
  function automatic logic [30:0][31:0] pow2_table(input int e);
    logic [30:0][31:0] t;
    for (int k = 0; k < 31; k++) t[k] = 32'((127 + e * k) << 23);
    return t;
  endfunction

  task automatic fill_coeff4(input logic [31:0] v);
    for (int k = 0; k < 32; k++) coeff4[k] = v;
  endtask

  task automatic fill_coeff31(input logic [31:0] v);
    for (int k = 0; k < 32; k++) coeff31[k] = v;
  endtask

  // Present a table for one cycle; the caller must be in IDLE, so the edge accepts it.
  task automatic accept4(input logic [30:0][31:0] t);
    table4    = t;
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic accept31(input logic [30:0][31:0] t);
    table31    = t;
    in_valid31 = 1'b1;
    @(posedge clk); #1;
    in_valid31 = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid, logging coeff_addr while busy.
  task automatic wait_out4(output int edges);
    edges = 0;
    addr_log4.delete();
    while (out_valid4 !== 1'b1 && edges < 200) begin
      if (busy4 === 1'b1) addr_log4.push_back(coeff_addr4);
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic wait_out31(output int edges);
    edges = 0;
    addr_log31.delete();
    while (out_valid31 !== 1'b1 && edges < 200) begin
      if (busy31 === 1'b1) addr_log31.push_back(coeff_addr31);
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid4, busy4, in_ready4} !== 3'b001 || result4 !== 32'h0 || coeff_addr4 !== '0) begin
      errors++;
      $display("[TB] FAIL reset4: valid/busy/ready=%b result=%h addr=%0d expected 001 00000000 0",
               {out_valid4, busy4, in_ready4}, result4, coeff_addr4);
    end
    checks++;
    if ({out_valid31, busy31, in_ready31} !== 3'b001 || result31 !== 32'h0 || coeff_addr31 !== '0) begin
      errors++;
      $display("[TB] FAIL reset31: valid/busy/ready=%b result=%h addr=%0d expected 001 00000000 0",
               {out_valid31, busy31, in_ready31}, result31, coeff_addr31);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // x = 2.0, all c_k = 1.0, 4 terms: 1 + 2 + 4 + 8 = 15.0.
  task automatic test_pow2_ones();
    int          lat;
    int          bad;
    logic [31:0] expv;
    fill_coeff4(ONE);
    out_ready4 = 1'b1;
    exp_q4.push_back(32'h41700000);
    accept4(pow2_table(1));
    wait_out4(lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("[TB] FAIL latency4: got %0d edges after accept, expected 4", lat);
    end
    bad = (addr_log4.size() != 4) ? 1 : 0;
    for (int k = 0; k < addr_log4.size() && k < 4; k++) if (addr_log4[k] !== IDX_W'(k)) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL addr_seq4: got %0d entries with %0d bad, expected 0,1,2,3", addr_log4.size(), bad);
    end
    expv = exp_q4.pop_front();
    checks++;
    if (result4 !== expv) begin
      errors++;
      $display("[TB] FAIL sum_x2: got %h expected %h", result4, expv);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL handoff4: out_valid=%b in_ready=%b expected 0 1", out_valid4, in_ready4);
    end
  endtask

  // Distinct coefficient/table patterns, each with an exact expected sum.
  task automatic test_weighted();
    logic [31:0] cset [3][4];
    int          xexp [3];
    logic [31:0] expv [3];
    int          lat;
    logic [31:0] got;
    // c_k = k, x = 2: 0 + 2 + 8 + 24 = 34.0
    cset[0] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000};
    xexp[0] = 1; expv[0] = 32'h42080000;
    // c_k = +1,-1,+1,-1, x = 2: 1 - 2 + 4 - 8 = -5.0
    cset[1] = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000};
    xexp[1] = 1; expv[1] = 32'hC0A00000;
    // c_k = 1, x = 0.5: 1 + 0.5 + 0.25 + 0.125 = 1.875
    cset[2] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    xexp[2] = -1; expv[2] = 32'h3FF00000;
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 4; k++) coeff4[k] = cset[v][k];
      exp_q4.push_back(expv[v]);
      accept4(pow2_table(xexp[v]));
      wait_out4(lat);
      got = exp_q4.pop_front();
      checks++;
      if (lat !== 4 || result4 !== got) begin
        errors++;
        $display("[TB] FAIL weighted%0d: got %h after %0d edges, expected %h after 4", v, result4, lat, got);
      end
      @(posedge clk); #1;
    end
  endtask

  // Zero coefficients give +0; the captured table must survive upstream changes.
  task automatic test_zero_capture();
    logic [30:0][31:0] rt;
    int                lat;
    logic [31:0]       expv;
    for (int k = 0; k < 31; k++) rt[k] = {1'($urandom), 8'($urandom_range(1, 200)), 23'($urandom)};
    fill_coeff4(32'h00000000);
    exp_q4.push_back(32'h00000000);
    accept4(rt);
    wait_out4(lat);
    expv = exp_q4.pop_front();
    checks++;
    if (result4 !== expv) begin
      errors++;
      $display("[TB] FAIL zero_coeff: got %h expected %h", result4, expv);
    end
    @(posedge clk); #1;
    fill_coeff4(ONE);
    exp_q4.push_back(32'h41700000);
    accept4(pow2_table(1));
    table4 = pow2_table(-1);
    wait_out4(lat);
    expv = exp_q4.pop_front();
    checks++;
    if (result4 !== expv) begin
      errors++;
      $display("[TB] FAIL capture: got %h expected %h", result4, expv);
    end
    @(posedge clk); #1;
  endtask

  // Result held under backpressure, DONE ignores in_valid, accept resumes after handoff.
  task automatic test_backpressure();
    int          lat;
    logic [31:0] expv;
    fill_coeff4(ONE);
    out_ready4 = 1'b0;
    exp_q4.push_back(32'h41700000);
    accept4(pow2_table(1));
    wait_out4(lat);
    expv = exp_q4.pop_front();
    checks++;
    if (lat !== 4 || result4 !== expv) begin
      errors++;
      $display("[TB] FAIL bp_first: got %h after %0d edges, expected %h after 4", result4, lat, expv);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        table4    = pow2_table(-1);
        in_valid4 = 1'b1;
      end
      if (i == 5) in_valid4 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid4 !== 1'b1 || result4 !== expv || in_ready4 !== 1'b0 || busy4 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: valid=%b result=%h ready=%b busy=%b expected 1 %h 0 0",
                 i, out_valid4, result4, in_ready4, busy4, expv);
      end
    end
    table4     = pow2_table(-1);
    in_valid4  = 1'b1;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: valid=%b ready=%b busy=%b expected 0 1 0", out_valid4, in_ready4, busy4);
    end
    exp_q4.push_back(32'h3FF00000);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_reaccept: busy=%b expected 1", busy4);
    end
    wait_out4(lat);
    expv = exp_q4.pop_front();
    checks++;
    if (lat !== 4 || result4 !== expv) begin
      errors++;
      $display("[TB] FAIL bp_second: got %h after %0d edges, expected %h after 4", result4, lat, expv);
    end
    @(posedge clk); #1;
  endtask

  // in_valid held high with out_ready high: one evaluation every N_TERMS+2 cycles.
  task automatic test_back_to_back();
    logic [30:0][31:0] tabs [3];
    logic [31:0]       exps [3];
    logic [31:0]       expv;
    int                accepts = 0;
    int                outs = 0;
    int                cyc = 0;
    int                last_acc = -1;
    logic              took;
    tabs[0] = pow2_table(1);  exps[0] = 32'h41700000;
    tabs[1] = pow2_table(-1); exps[1] = 32'h3FF00000;
    tabs[2] = pow2_table(0);  exps[2] = 32'h40800000;
    fill_coeff4(ONE);
    out_ready4 = 1'b1;
    table4     = tabs[0];
    in_valid4  = 1'b1;
    while (outs < 3 && cyc < 60) begin
      took = in_valid4 && in_ready4;
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        exp_q4.push_back(exps[accepts]);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 6) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles between accepts, expected 6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        accepts++;
        if (accepts < 3) table4 = tabs[accepts];
        else in_valid4 = 1'b0;
      end
      if (out_valid4 === 1'b1) begin
        checks++;
        if (exp_q4.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_spurious: got result %h with nothing expected", result4);
        end else begin
          expv = exp_q4.pop_front();
          if (result4 !== expv) begin
            errors++;
            $display("[TB] FAIL b2b_result%0d: got %h expected %h", outs, result4, expv);
          end
        end
        outs++;
      end
    end
    in_valid4 = 1'b0;
    checks++;
    if (outs !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d results in %0d cycles, expected 3", outs, cyc);
    end
    @(posedge clk); #1;
  endtask

  // Full 31-term run with x = 1.0 and c_k = 1.0: sum is 31.0, busy for 31 cycles.
  task automatic test_full_length();
    int          lat;
    int          bad;
    logic [31:0] expv;
    fill_coeff31(ONE);
    out_ready31 = 1'b1;
    exp_q31.push_back(32'h41F80000);
    accept31(pow2_table(0));
    wait_out31(lat);
    checks++;
    if (lat !== 31 || addr_log31.size() !== 31) begin
      errors++;
      $display("[TB] FAIL full_timing: got %0d edges, busy %0d cycles, expected 31 31", lat, addr_log31.size());
    end
    bad = 0;
    for (int k = 0; k < addr_log31.size(); k++) if (addr_log31[k] !== IDX_W'(k)) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL full_addr_seq: got %0d out-of-order addresses, expected 0", bad);
    end
    expv = exp_q31.pop_front();
    checks++;
    if (result31 !== expv) begin
      errors++;
      $display("[TB] FAIL full_sum: got %h expected %h", result31, expv);
    end
    @(posedge clk); #1;
  endtask

  // Reset at term 10 discards the run; a fresh run then completes normally.
  task automatic test_reset_mid();
    int          lat;
    logic [31:0] expv;
    fill_coeff31(ONE);
    accept31(pow2_table(0));
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (coeff_addr31 !== IDX_W'(10) || busy31 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_addr: addr=%0d busy=%b expected 10 1", coeff_addr31, busy31);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid31 !== 1'b0 || result31 !== 32'h0 || in_ready31 !== 1'b1 ||
        coeff_addr31 !== '0 || busy31 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: valid=%b result=%h ready=%b addr=%0d busy=%b expected 0 00000000 1 0 0",
               out_valid31, result31, in_ready31, coeff_addr31, busy31);
    end
    exp_q31.push_back(32'h41F80000);
    accept31(pow2_table(0));
    wait_out31(lat);
    expv = exp_q31.pop_front();
    checks++;
    if (lat !== 31 || result31 !== expv) begin
      errors++;
      $display("[TB] FAIL mid_rerun: got %h after %0d edges, expected %h after 31", result31, lat, expv);
    end
    @(posedge clk); #1;
  endtask

`ifdef SERIES_TERM_LIMIT_EN
  // n_terms = 3 gives 1 + 2 + 4 = 7.0; n_terms = 0 gives +0 on the edge after accept.
  task automatic test_term_limit();
    int          lat;
    logic [31:0] expv;
    fill_coeff4(ONE);
    out_ready4 = 1'b1;
    n_terms4   = 5'd3;
    exp_q4.push_back(32'h40E00000);
    accept4(pow2_table(1));
    wait_out4(lat);
    expv = exp_q4.pop_front();
    checks++;
    if (lat !== 3 || result4 !== expv) begin
      errors++;
      $display("[TB] FAIL limit3: got %h after %0d edges, expected %h after 3", result4, lat, expv);
    end
    @(posedge clk); #1;
    n_terms4 = 5'd0;
    exp_q4.push_back(32'h00000000);
    accept4(pow2_table(1));
    wait_out4(lat);
    expv = exp_q4.pop_front();
    checks++;
    if (lat !== 1 || result4 !== expv) begin
      errors++;
      $display("[TB] FAIL limit0: got %h after %0d edges, expected %h after 1", result4, lat, expv);
    end
    @(posedge clk); #1;
    n_terms4 = 5'd31;
  endtask
`endif

  initial begin
    rst         = 1'b1;
    in_valid4   = 1'b0;
    out_ready4  = 1'b1;
    table4      = '0;
    in_valid31  = 1'b0;
    out_ready31 = 1'b1;
    table31     = '0;
`ifdef SERIES_TERM_LIMIT_EN
    n_terms4    = 5'd31;
    n_terms31   = 5'd31;
`endif
    fill_coeff4(ONE);
    fill_coeff31(ONE);
    test_reset();
    test_pow2_ones();
    test_weighted();
    test_zero_capture();
    test_backpressure();
    test_back_to_back();
    test_full_length();
    test_reset_mid();
`ifdef SERIES_TERM_LIMIT_EN
    test_term_limit();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
